gin_issue_queue: RTL and testbench

GIN_ISSUE_QUEUE -- requirements
Module: gin_issue_queue

---
 rtl/gin_issue_queue.sv | 91 +++++++++
 tb/tb_gin_issue_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gin_issue_queue.sv
// Issue queue feeding the GIN bus: a DEPTH-entry {tag, data} FIFO drained by an
// IDLE/ISSUE/HOLD sequencer that emits one bus_enable strobe per entry.
module gin_issue_queue #(
    parameter int BITWIDTH   = 16,
    parameter int TAG_LENGTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TAG_LENGTH-1:0]    in_tag,
    input  logic [BITWIDTH-1:0]      in_data,
    input  logic                     bus_ready,
    output logic                     bus_enable,
    output logic [TAG_LENGTH-1:0]    tag,
    output logic [BITWIDTH-1:0]      data_source,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t                  state;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [TAG_LENGTH-1:0]   tag_mem  [DEPTH];
    logic [BITWIDTH-1:0]     data_mem [DEPTH];
    logic                    push;
    logic                    pop;

    assign in_ready = (count < CNT_W'(DEPTH));
    assign busy     = (count != '0) || (state != IDLE);
    assign push     = in_valid && in_ready && !rstb;
    assign pop      = (state == IDLE) && (count != '0) && bus_ready && !rstb;

    // Storage carries no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr]  <= in_tag;
            data_mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            state       <= IDLE;
            bus_enable  <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tag         <= '0;
            data_source <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap naturally.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PTR_W'(1);
                tag         <= tag_mem[rd_ptr];
                data_source <= data_mem[rd_ptr];
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            case (state)
                IDLE: begin
                    if (pop) begin
                        state      <= ISSUE;
                        bus_enable <= 1'b1;
                    end
                end
                ISSUE: begin
                    state      <= HOLD;
                    bus_enable <= 1'b0;
                end
                HOLD: begin
                    // Extra cycle lets the bus drop bus_ready before we look again.
                    state      <= IDLE;
                    bus_enable <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    bus_enable <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gin_issue_queue.sv
// Randomized scoreboard bench for gin_issue_queue: a queue-level reference model
// predicts accepts and issue timing, a monitor checks every cycle.
module tb_gin_issue_queue;
    localparam int BITWIDTH   = 16;
    localparam int TAG_LENGTH = 4;
    localparam int DEPTH      = 4;
    localparam int SBN        = 1024;

    logic                    clk = 1'b0;
    logic                    rstb = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [TAG_LENGTH-1:0]   in_tag = '0;
    logic [BITWIDTH-1:0]     in_data = '0;
    logic                    bus_ready = 1'b0;
    logic                    bus_enable;
    logic [TAG_LENGTH-1:0]   tag;
    logic [BITWIDTH-1:0]     data_source;
    logic [$clog2(DEPTH):0]  count;
    logic                    busy;

    gin_issue_queue #(.BITWIDTH(BITWIDTH), .TAG_LENGTH(TAG_LENGTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready),
        .in_tag(in_tag), .in_data(in_data), .bus_ready(bus_ready),
        .bus_enable(bus_enable), .tag(tag), .data_source(data_source),
        .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model state (written only by the model process)
    int cyc = 0;
    int mcount = 0;
    int last_pop = -100;
    bit exp_en = 1'b0;
    bit rst_last = 1'b0;
    int sb_tail = 0;
    logic [TAG_LENGTH-1:0] sb_tag  [SBN];
    logic [BITWIDTH-1:0]   sb_data [SBN];

    // Control flags from the stimulus process
    bit do_final = 1'b0;
    bit tmo_flag = 1'b0;

    // Monitor state
    int sb_head = 0;
    int total = 0;
    int bad = 0;
    bit final_done = 1'b0;
    logic [TAG_LENGTH-1:0] hold_tag  = '0;
    logic [BITWIDTH-1:0]   hold_data = '0;

    // Model: queue occupancy plus "at most one issue every 3 cycles, only when
    // the bus is ready and something is queued".
    always @(posedge clk) begin
        bit pop_m;
        bit push_m;
        cyc = cyc + 1;
        rst_last = rstb;
        if (rstb) begin
            mcount   = 0;
            last_pop = -100;
            exp_en   = 1'b0;
        end else begin
            pop_m  = (mcount != 0) && bus_ready && (cyc - last_pop >= 3);
            push_m = in_valid && (mcount < DEPTH);
            if (push_m) begin
                sb_tag[sb_tail % SBN]  = in_tag;
                sb_data[sb_tail % SBN] = in_data;
                sb_tail = sb_tail + 1;
            end
            if (pop_m) last_pop = cyc;
            mcount = mcount + int'(push_m) - int'(pop_m);
            exp_en = pop_m;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares DUT outputs to model/scoreboard away from the active edge.
    always @(negedge clk) begin
        if (rst_last) begin
            sb_head   = sb_tail;
            hold_tag  = '0;
            hold_data = '0;
        end
        chk("bus_enable", 32'(bus_enable), 32'(exp_en));
        if (bus_enable) begin
            if (sb_head == sb_tail) begin
                chk("issue_without_entry", 32'(sb_tail - sb_head), 32'd1);
            end else begin
                chk("issue_tag", 32'(tag), 32'(sb_tag[sb_head % SBN]));
                chk("issue_data", 32'(data_source), 32'(sb_data[sb_head % SBN]));
                hold_tag  = sb_tag[sb_head % SBN];
                hold_data = sb_data[sb_head % SBN];
                sb_head   = sb_head + 1;
            end
        end else begin
            chk("held_tag", 32'(tag), 32'(hold_tag));
            chk("held_data", 32'(data_source), 32'(hold_data));
        end
        chk("count", 32'(count), 32'(mcount));
        chk("in_ready", 32'(in_ready), 32'(mcount < DEPTH));
        chk("busy", 32'(busy), 32'((mcount != 0) || (cyc - last_pop <= 1)));
        if (do_final && !final_done) begin
            chk("drained", 32'(sb_tail - sb_head), 32'd0);
            chk("no_timeout", 32'(tmo_flag), 32'd0);
            final_done = 1'b1;
        end
    end

    task automatic drive(input bit v, input int t, input int d, input bit br);
        in_valid  = v;
        in_tag    = TAG_LENGTH'(t);
        in_data   = BITWIDTH'(d);
        bus_ready = br;
        @(negedge clk);
    endtask

    // Holds the offer until the queue takes it (bounded).
    task automatic push_one(input int t, input int d, input bit br);
        bit ok;
        in_valid  = 1'b1;
        in_tag    = TAG_LENGTH'(t);
        in_data   = BITWIDTH'(d);
        bus_ready = br;
        for (int k = 0; k < 50; k++) begin
            ok = in_ready;
            @(negedge clk);
            if (ok) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        tmo_flag = 1'b1;
    endtask

    task automatic idle(input int n, input bit br);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 0, br);
    endtask

    initial begin
        bit seen;
        idle(3, 1'b1);
        rstb = 1'b0;
        idle(2, 1'b1);

        // Single packet into an empty queue
        push_one(3, 'h00A5, 1'b1);
        idle(6, 1'b1);

        // Fill with bus stalled; the fifth offer is refused
        for (int i = 0; i < 5; i++) drive(1'b1, i + 5, $urandom, 1'b0);
        idle(16, 1'b1);

        // Backpressure with two entries pending
        push_one(1, $urandom, 1'b0);
        push_one(2, $urandom, 1'b0);
        idle(10, 1'b0);
        idle(8, 1'b1);

        // Push and pop on the same edge at count 3
        for (int i = 0; i < 3; i++) push_one(i + 10, $urandom, 1'b0);
        push_one(13, $urandom, 1'b1);
        idle(14, 1'b1);

        // Streaming with wrap-around
        for (int i = 0; i < 10; i++) push_one(i % 16, $urandom, 1'b1);
        idle(16, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 3) != 0);
        idle(16, 1'b1);

        // Reset while in HOLD with two entries still queued
        for (int i = 0; i < 3; i++) push_one(i + 4, $urandom, 1'b0);
        bus_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = bus_enable;
        end
        if (!seen) tmo_flag = 1'b1;
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        rstb = 1'b0;
        idle(8, 1'b1);
        push_one(9, 'h1234, 1'b1);
        idle(8, 1'b1);

        do_final = 1'b1;
        idle(3, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
